serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock. It uses a single full-adder cell as `a + ~b + 1`, so it is the subtract-direction counterpart of the team's full adder. It sits behind a start/done handshake so a controller can launch an operation and collect the difference, borrow and signed overflow when `done` pulses. It trades area for latency: WIDTH cycles per operation, one adder cell regardless of WIDTH.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: launch request; sampled only in IDLE.
- `a` input WIDTH: minuend; sampled on the accepting edge only.
- `b` input WIDTH: subtrahend; sampled on the accepting edge only.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse; result outputs are valid from this cycle on.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`; holds its value until the next `done`.
- `bout` output 1: unsigned borrow, 1 iff `a < b` unsigned; held like `diff`.
- `ovf` output 1: signed overflow of `a - b` as two's complement; held like `diff`.

## Operation
- **States:**
  - IDLE: `busy=0`. `start=1` latches `a` into shift register SA and `~b` into SB. Sets carry register `c=1`, clears the bit counter, and goes to RUN.
  - RUN: each cycle processes bit i = counter, LSB first.
    - `s = SA[0] ^ SB[0] ^ c`; `c <= maj(SA[0], SB[0], c)`.
    - SA and SB shift right; `s` enters the MSB of internal result register SR, which shifts right.
    - When i = WIDTH-1, record `cin_msb` (the carry into the MSB) and go to DONE.
  - DONE: `done=1` for exactly this cycle. `diff <= SR` and `bout <= ~c` are loaded on the edge entering DONE. `ovf <= cin_msb ^ c` is loaded on that same edge. Returns to IDLE unconditionally.
- **start outside IDLE:** ignored in RUN and DONE; no queuing. Operands are not re-sampled.
- **Output hold:** `diff`, `bout` and `ovf` change only on the edge entering DONE or on reset. They keep the previous result throughout RUN.
- **Counter width:** `clog2(WIDTH)` bits; no wrap occurs since RUN exits at WIDTH-1.
- **Reset:** `rst=1` on any edge forces IDLE with `busy=0`, `done=0`, `diff=0`, `bout=0` and `ovf=0`. SA, SB, SR, `c` and the counter are cleared.
  - Reset overrides `start` on the same edge.
  - Reset mid-RUN abandons the operation; no `done` is produced.

## Timing
- Call the accepting edge E0 (`start=1` in IDLE, `rst=0`).
  - `busy` rises after E0.
  - Bits 0..WIDTH-1 are processed on edges E1..E(WIDTH).
  - `done` is high, with new outputs valid, in the cycle after E(WIDTH).
  - `busy` and `done` fall after E(WIDTH+1).
- **Latency:** WIDTH+1 cycles from the accepting edge to the `done` cycle. `busy` is high for WIDTH+1 cycles.
- **Back-to-back:** the earliest next accept is the edge ending the DONE cycle's successor (IDLE) cycle. Throughput is one operation per WIDTH+2 cycles.
- **Outputs:** all are registered; there is no combinational path from inputs to outputs.

## Test plan
All cases use WIDTH=8 and start from IDLE unless stated.
- `a=0x05`, `b=0x03`, one-cycle `start` -> `done` exactly 9 cycles after the accepting edge; `diff=0x02`, `bout=0`, `ovf=0`. `busy` is high for 9 cycles.
- `a=0x03`, `b=0x05` -> `diff=0xFE`, `bout=1`, `ovf=0`. Then `a=0x00`, `b=0x00` -> `diff=0x00`, `bout=0`, `ovf=0`.
- Signed overflow:
  - `a=0x80`, `b=0x01` -> `diff=0x7F`, `bout=0`, `ovf=1`.
  - `a=0x7F`, `b=0xFF` -> `diff=0x80`, `bout=1`, `ovf=1`.
- `a=0x10`, `b=0x01` accepted.
  - Then `start=1` with `a=0xFF`, `b=0x00` held during RUN and DONE -> single `done` with `diff=0x0F`.
  - The second request is accepted only once the block is back in IDLE, giving `diff=0xFF` one op later.
- Accept `a=0x05`, `b=0x03`, hold the result; next op `a=0x09`, `b=0x01`.
  - During RUN, `diff` must read 0x02.
  - It changes to 0x08 exactly on the `done` cycle.
- Accept `a=0x44`, `b=0x11`, assert `rst` for one cycle on E4.
  - After the reset edge: `busy=0`, `diff=0`, `bout=0`, `ovf=0`, and no `done` for 20 cycles.
  - A fresh `a=0x44`, `b=0x11` then yields `diff=0x33`.
  - Also check that `rst` and `start` on the same edge leave the block in IDLE.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, one bit per clock, LSB first.
// A single full-adder cell is reused each cycle; start/done handshake around it.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_next;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    s       = sa[0] ^ sb[0] ^ c;
    c_next  = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
    sr_next = {s, sr[WIDTH-1:1]};
  end

  // On the last bit, c still holds the carry into the MSB, so overflow is c ^ c_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= ~b;
            c     <= 1'b1;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          c   <= c_next;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            diff  <= sr_next;
            bout  <= ~c_next;
            ovf   <= c ^ c_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a scoreboard queue of expected results.
// Expected values come from an arithmetic model of a - b.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t         sb_q[$];
  exp_t         last_exp;
  int           passed;
  int           total;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one request on a negedge; the following posedge is the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_accept_busy"}, busy, 1);
    sb_q.push_back(model(x, y));
  endtask

  // Entered at accepting edge + #1 (cycle 1); waits for done, checks latency, hold and result.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   cyc;
    int   busy_cycles;
    bit   held;
    cyc         = 1;
    busy_cycles = 0;
    held        = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_cycles++;
      if (diff !== last_exp.d || bout !== last_exp.bo || ovf !== last_exp.ov) held = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy) busy_cycles++;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc, W + 1);
    check({tag, "_busy_cycles"}, busy_cycles, W + 1);
    check({tag, "_hold_before_done"}, held, 1);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_diff"}, diff, e.d);
      check({tag, "_bout"}, bout, e.bo);
      check({tag, "_ovf"}, ovf, e.ov);
      last_exp = e;
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, done, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    bit saw_done;
    passed   = 0;
    total    = 0;
    last_exp = '0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    check("reset_ovf", ovf, 0);

    applyStimulus(8'h05, 8'h03, "sub_5_3");
    checkOutput("sub_5_3");
    applyStimulus(8'h03, 8'h05, "sub_3_5");
    checkOutput("sub_3_5");
    applyStimulus(8'h00, 8'h00, "sub_0_0");
    checkOutput("sub_0_0");
    applyStimulus(8'h80, 8'h01, "ovf_80_01");
    checkOutput("ovf_80_01");
    applyStimulus(8'h7F, 8'hFF, "ovf_7f_ff");
    checkOutput("ovf_7f_ff");

    // start held high through RUN and DONE must not queue a second operation.
    applyStimulus(8'h10, 8'h01, "ignore_first");
    a     = 8'hFF;
    b     = 8'h00;
    start = 1'b1;
    checkOutput("ignore_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignore_second_accept", busy, 1);
    sb_q.push_back(model(8'hFF, 8'h00));
    checkOutput("ignore_second");

    applyStimulus(8'h05, 8'h03, "hold_a");
    checkOutput("hold_a");
    applyStimulus(8'h09, 8'h01, "hold_b");
    checkOutput("hold_b");

    // Reset sampled on E4 abandons the operation in flight.
    applyStimulus(8'h44, 8'h11, "abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    last_exp = '0;
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_bout", bout, 0);
    check("abort_ovf", ovf, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_no_done", saw_done, 0);
    applyStimulus(8'h44, 8'h11, "after_abort");
    checkOutput("after_abort");

    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_diff", diff, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_still_idle", busy, 0);
    check("rst_start_no_done", done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
